// File: rtl/fifo_sched_pkg.sv
// Shared types and default sizing for the FIFO read scheduler.
// Latency: none (declarations only).
// Backpressure: n/a.
package fifo_sched_pkg;

   localparam int DEF_NUM_FIFO   = 16;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_BURST_LEN  = 4;

   // Per-word flow: pick a channel, strobe it, capture the word, hold it for the consumer.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } sched_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request bit at or above start, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module rr_priority_picker #(
   parameter int N = 16,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] grant,
   output logic         any_req
);

   int            pos;
   logic [W-1:0]  idx;

   // Walk the request vector from start upward with wrap; keep the first hit.
   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      pos     = 0;
      idx     = '0;
      for (int i = 0; i < N; i++) begin
         pos = int'(start) + i;
         if (pos >= N) begin
            pos = pos - N;
         end
         idx = W'(pos);
         if (!any_req && req[idx]) begin
            grant   = idx;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_rd_scheduler.sv
// Drains NUM_FIFO read-side FIFOs round-robin, up to BURST_LEN words per grant.
// Latency: strobe -> out_valid is 2 cycles (1 FIFO read + 1 capture register).
// Backpressure: a held word blocks further strobes until out_ready accepts it.
module fifo_rd_scheduler
   import fifo_sched_pkg::*;
#(
   parameter int NUM_FIFO   = DEF_NUM_FIFO,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BURST_LEN  = DEF_BURST_LEN
) (
   input  logic                             rd_clk,
   input  logic                             rd_rst,
   input  logic                             enable,
   input  logic [NUM_FIFO-1:0]              empty,
   output logic [NUM_FIFO-1:0]              rd_en,
   input  logic [NUM_FIFO*DATA_WIDTH-1:0]   rd_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [$clog2(NUM_FIFO)-1:0]      out_ch,
   output logic                             out_last
);

   localparam int CH_W = $clog2(NUM_FIFO);
   localparam int BC_W = $clog2(BURST_LEN + 1);

   sched_state_t           state;
   logic [CH_W-1:0]        grant;
   logic [CH_W-1:0]        rr_ptr;
   logic [BC_W-1:0]        burst_cnt;
   logic [BC_W-1:0]        burst_cnt_nxt;
   logic [CH_W-1:0]        pick_ch;
   logic                   pick_any;
   logic [DATA_WIDTH-1:0]  grant_word;
   logic [CH_W-1:0]        grant_plus1;

   // Search for the next channel with data, starting at the round-robin pointer.
   rr_priority_picker #(
      .N (NUM_FIFO),
      .W (CH_W)
   ) u_picker (
      .req     (~empty),
      .start   (rr_ptr),
      .grant   (pick_ch),
      .any_req (pick_any)
   );

   // Word slice of the granted channel, next pointer value and burst count increment.
   always_comb begin
      grant_word    = rd_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      grant_plus1   = (grant == CH_W'(NUM_FIFO - 1)) ? '0 : grant + CH_W'(1);
      burst_cnt_nxt = burst_cnt + BC_W'(1);
   end

   // Strobe only in READ and only if the granted FIFO really has a word this cycle.
   always_comb begin
      rd_en = '0;
      if (state == READ && !empty[grant]) begin
         rd_en[grant] = 1'b1;
      end
   end

   // Scheduler FSM; all consumer-facing outputs are registered here.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable && pick_any) begin
                  grant     <= pick_ch;
                  burst_cnt <= '0;
                  state     <= READ;
               end
            end
            READ: begin
               // A FIFO that ran dry between grant and strobe ends the burst quietly.
               if (empty[grant]) begin
                  rr_ptr <= grant_plus1;
                  state  <= IDLE;
               end else begin
                  state  <= CAPTURE;
               end
            end
            CAPTURE: begin
               // empty here already reflects the pop, so it flags the FIFO's final word.
               out_data  <= grant_word;
               out_ch    <= grant;
               out_valid <= 1'b1;
               out_last  <= (burst_cnt_nxt == BC_W'(BURST_LEN)) || empty[grant];
               burst_cnt <= burst_cnt_nxt;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     rr_ptr <= grant_plus1;
                     state  <= IDLE;
                  end else begin
                     state  <= READ;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// Directed bench for fifo_rd_scheduler with behavioural FIFOs and an expected-word queue.
// Latency: FIFO model returns data one cycle after rd_en.
// Backpressure: out_ready driven from the stimulus sequence, stalled on demand.
module tb_fifo_rd_scheduler;

   typedef struct packed {
      logic [3:0]  ch;
      logic [15:0] dat;
      logic        last;
   } exp_t;

   logic          rd_clk;
   logic          rd_rst = 1'b1;
   logic          enable = 1'b0;
   logic [15:0]   empty;
   logic [15:0]   rd_en;
   logic [255:0]  rd_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [15:0]   out_data;
   logic [3:0]    out_ch;
   logic          out_last;

   logic [15:0]   mem [16][16];
   logic [4:0]    wrp [16];
   logic [4:0]    rdp [16];
   logic          empty_ovr = 1'b1;

   exp_t          sb [$];
   int            checks = 0;
   int            errors = 0;

   fifo_rd_scheduler dut (
      .rd_clk    (rd_clk),
      .rd_rst    (rd_rst),
      .enable    (enable),
      .empty     (empty),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_last  (out_last)
   );

   initial begin
      rd_clk = 1'b0;
      forever #5 rd_clk = ~rd_clk;
   end

   // Empty flags from the FIFO model, optionally forced low.
   always_comb begin
      empty = '0;
      for (int k = 0; k < 16; k++) begin
         empty[k] = !empty_ovr && (rdp[k] == wrp[k]);
      end
   end

   // FIFO read side: one-cycle read latency, pop on strobe.
   always @(posedge rd_clk) begin
      for (int k = 0; k < 16; k++) begin
         if (rd_en[k]) begin
            rd_data[k*16 +: 16] <= mem[k][rdp[k][3:0]];
            rdp[k]              <= rdp[k] + 5'd1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int ch, input logic [15:0] d);
      mem[ch][wrp[ch][3:0]] = d;
      wrp[ch] = wrp[ch] + 5'd1;
   endtask

   task automatic expect_word(input int ch, input logic [15:0] d, input logic last);
      exp_t e;
      e.ch   = 4'(ch);
      e.dat  = d;
      e.last = last;
      sb.push_back(e);
   endtask

   // Consume outputs until the queue is empty, optionally stalling 10 cycles after stall_at words.
   task automatic drain(input int budget, input int stall_at);
      int          cycles = 0;
      int          accepted = 0;
      int          stall_left = 0;
      bit          have_held = 0;
      logic [15:0] held = '0;
      exp_t        e;
      while (sb.size() > 0 && cycles < budget) begin
         @(negedge rd_clk);
         cycles++;
         out_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         if ($countones(rd_en) > 1) check("rd_en_onehot", 32'($countones(rd_en)), 32'd1);
         if (out_valid && !out_ready) begin
            check("bp_rd_en", 32'(rd_en), 32'd0);
            if (have_held) check("bp_stable", 32'(out_data), 32'(held));
            held      = out_data;
            have_held = 1;
         end
         if (out_valid && out_ready) begin
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.dat));
            check("out_ch", 32'(out_ch), 32'(e.ch));
            check("out_last", 32'(out_last), 32'(e.last));
            accepted++;
            if (accepted == stall_at) stall_left = 10;
         end
      end
      out_ready = 1'b1;
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
      repeat (8) begin
         @(negedge rd_clk);
         if (out_valid) check("spurious_out", 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      bit found;
      for (int k = 0; k < 16; k++) begin
         wrp[k] = '0;
         rdp[k] = '0;
      end
      enable = 1'b1;

      // Reset held with every channel claiming data.
      repeat (3) begin
         @(negedge rd_clk);
         check("rst_rd_en", 32'(rd_en), 32'd0);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_out_ch", 32'(out_ch), 32'd0);
         check("rst_out_data", 32'(out_data), 32'd0);
         check("rst_out_last", 32'(out_last), 32'd0);
      end
      empty_ovr = 1'b0;
      @(negedge rd_clk);
      rd_rst = 1'b0;
      @(negedge rd_clk);

      // Single channel: two bursts from ch5.
      for (int i = 0; i < 6; i++) load(5, 16'hA0 + 16'(i));
      expect_word(5, 16'hA0, 0);
      expect_word(5, 16'hA1, 0);
      expect_word(5, 16'hA2, 0);
      expect_word(5, 16'hA3, 1);
      expect_word(5, 16'hA4, 0);
      expect_word(5, 16'hA5, 1);
      drain(100, -1);

      // Round robin from pointer 0, wrapping back to ch0 after ch15.
      rd_rst = 1'b1;
      @(negedge rd_clk);
      rd_rst = 1'b0;
      @(negedge rd_clk);
      load(0, 16'h0100);
      load(3, 16'h0300);
      load(15, 16'h0F00);
      expect_word(0, 16'h0100, 1);
      expect_word(3, 16'h0300, 1);
      expect_word(15, 16'h0F00, 1);
      drain(100, -1);
      load(0, 16'h0101);
      expect_word(0, 16'h0101, 1);
      drain(50, -1);

      // Backpressure after the first word of a ch2 burst.
      for (int i = 0; i < 4; i++) load(2, 16'h0200 + 16'(i));
      expect_word(2, 16'h0200, 0);
      expect_word(2, 16'h0201, 0);
      expect_word(2, 16'h0202, 0);
      expect_word(2, 16'h0203, 1);
      drain(100, 1);

      // Early empty on ch7, then search resumes above ch7 and wraps to ch6.
      load(7, 16'h0700);
      load(7, 16'h0701);
      expect_word(7, 16'h0700, 0);
      expect_word(7, 16'h0701, 1);
      drain(50, -1);
      load(6, 16'h0600);
      load(8, 16'h0800);
      expect_word(8, 16'h0800, 1);
      expect_word(6, 16'h0600, 1);
      drain(50, -1);

      // Reset during the capture cycle of ch9; restart picks lowest channel.
      load(4, 16'h0400);
      for (int i = 0; i < 3; i++) load(9, 16'h0900 + 16'(i));
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge rd_clk);
         if (rd_en[9]) found = 1;
      end
      check("ch9_strobe_seen", 32'(found), 32'd1);
      @(negedge rd_clk);
      rd_rst = 1'b1;
      #1;
      check("midrst_rd_en", 32'(rd_en), 32'd0);
      @(negedge rd_clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      rd_rst = 1'b0;
      expect_word(4, 16'h0400, 1);
      expect_word(9, 16'h0901, 0);
      expect_word(9, 16'h0902, 1);
      drain(100, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
